// File: rtl/csa_resolve_pkg.sv
// Shared widths, FSM state encoding and sizing helper for the carry-save resolver.
package csa_resolve_pkg;

    localparam int CSA_W     = 132;
    localparam int CSA_CHUNK = 33;

    typedef enum logic [1:0] {
        CSAR_IDLE = 2'd0,
        CSAR_BUSY = 2'd1,
        CSAR_DONE = 2'd2
    } csar_state_e;

    // Counter width for n chunks; never collapses to zero bits.
    function automatic int csa_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/csa_resolve_if.sv
// Operand-in / result-out handshake bundle between compressor tree, resolver and result mux.
interface csa_resolve_if #(
    parameter int W = csa_resolve_pkg::CSA_W
) ();
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_c;
    logic [W-1:0] in_s;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_res;

    modport master (
        output in_valid, in_c, in_s, out_ready,
        input  in_ready, out_valid, out_res
    );

    modport slave (
        input  in_valid, in_c, in_s, out_ready,
        output in_ready, out_valid, out_res
    );
endinterface

// File: rtl/csa_chunk_add.sv
// CHUNK-bit adder with carry-in/carry-out; pure combinational, no backpressure.
module csa_chunk_add #(
    parameter int CHUNK = 33
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_ci,
    output logic [CHUNK-1:0] o_sum,
    output logic             o_co
);
    assign {o_co, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_ci};
endmodule

// File: rtl/csa_resolve.sv
// Resolves a carry-save pair to binary, one CHUNK slice per cycle; latency NCHUNK cycles.
// Result held with out_valid until out_ready; a new pair may be accepted in the same cycle as the result handshake.
module csa_resolve
    import csa_resolve_pkg::*;
#(
    parameter int W     = CSA_W,
    parameter int CHUNK = CSA_CHUNK
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    csa_resolve_if.slave bus
);
    localparam int NCHUNK = W / CHUNK;
    localparam int KW     = csa_cnt_w(NCHUNK);
    localparam int BW     = $clog2(W);
    localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

    csar_state_e      r_state;
    csar_state_e      w_state_nxt;
    logic [KW-1:0]    r_k;
    logic             r_cy;
    logic [W-1:0]     r_op_c;
    logic [W-1:0]     r_op_s;
    logic [W-1:0]     r_res;

    logic [BW-1:0]    w_base;
    logic [CHUNK-1:0] w_a;
    logic [CHUNK-1:0] w_b;
    logic [CHUNK-1:0] w_sum;
    logic             w_co;
    logic             w_in_rdy;
    logic             w_accept;

    // Flush masks in_ready so an offered operand in the flush cycle is never taken.
    assign w_in_rdy  = !flush && ((r_state == CSAR_IDLE) ||
                                  ((r_state == CSAR_DONE) && bus.out_ready));
    assign w_accept  = bus.in_valid && w_in_rdy;

    assign bus.in_ready  = w_in_rdy;
    assign bus.out_valid = (r_state == CSAR_DONE);
    assign bus.out_res   = r_res;

    assign w_base = BW'(r_k) * BW'(CHUNK);
    assign w_a    = r_op_c[w_base +: CHUNK];
    assign w_b    = r_op_s[w_base +: CHUNK];

    csa_chunk_add #(
        .CHUNK (CHUNK)
    ) u_add (
        .i_a   (w_a),
        .i_b   (w_b),
        .i_ci  (r_cy),
        .o_sum (w_sum),
        .o_co  (w_co)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            CSAR_IDLE: if (w_accept) w_state_nxt = CSAR_BUSY;
            CSAR_BUSY: if (r_k == K_LAST) w_state_nxt = CSAR_DONE;
            CSAR_DONE: if (bus.out_ready) w_state_nxt = w_accept ? CSAR_BUSY : CSAR_IDLE;
            default:   w_state_nxt = CSAR_IDLE;
        endcase
        if (flush) begin
            w_state_nxt = CSAR_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= CSAR_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Carry out of the top chunk is simply dropped: the next accept clears r_cy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k    <= '0;
            r_cy   <= 1'b0;
            r_op_c <= '0;
            r_op_s <= '0;
            r_res  <= '0;
        end else if (flush) begin
            r_k  <= '0;
            r_cy <= 1'b0;
        end else if (w_accept) begin
            r_op_c <= bus.in_c;
            r_op_s <= bus.in_s;
            r_k    <= '0;
            r_cy   <= 1'b0;
        end else if (r_state == CSAR_BUSY) begin
            r_res[w_base +: CHUNK] <= w_sum;
            r_cy                   <= w_co;
            r_k                    <= (r_k == K_LAST) ? '0 : r_k + KW'(1);
        end
    end

endmodule
